// File: rtl/nor_gate_test_sequencer.sv
// Exhaustive self-test sequencer for the NOR-only gate library (NOT/AND/OR/XNOR/XOR/NAND).
// Latency: each vector takes SETTLE_CYCLES+1 cycles; done rises 24*(SETTLE_CYCLES+1) cycles after start.
// Backpressure: none; start is ignored while busy, abort cancels a run, and abort beats start.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start, abort         run control (start honoured in IDLE/DONE, abort in SETTLE/CHECK)
//   gate_sel, tv_a, tv_b stimulus to the external gate bank
//   dut_y                gate bank response
//   busy, done, pass     run status (done/pass are levels held until the next start)
//   err_cnt              saturating mismatch count for the current or last run
//   fail_valid/gate/vec  first mismatch captured in this run
//
// Optional build macro: NOR_SEQ_STOP_ON_FAIL_EN ends the run at the first mismatch.

module nor_gate_test_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [2:0]       gate_sel,
  output logic             tv_a,
  output logic             tv_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       fail_gate,
  output logic [1:0]       fail_vec
);

`ifdef NOR_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [2:0]       LAST_GATE   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_nxt;
  logic [2:0]       gate_q, gate_nxt;
  logic [1:0]       vec_q, vec_nxt;
  logic [3:0]       cnt_q, cnt_nxt;
  logic [ERR_W-1:0] err_q, err_nxt;
  logic             fv_q, fv_nxt;
  logic [2:0]       fg_q, fg_nxt;
  logic [1:0]       fvec_q, fvec_nxt;
  logic             busy_q, done_q, pass_q;
  logic             golden;
  logic             mismatch;
  logic             last_vec;

  // Behavioural reference for the gate under test; a = vec[1], b = vec[0].
  always_comb begin
    golden = 1'b0;
    case (gate_q)
      3'd0:    golden = ~vec_q[1];
      3'd1:    golden = vec_q[1] & vec_q[0];
      3'd2:    golden = vec_q[1] | vec_q[0];
      3'd3:    golden = ~(vec_q[1] ^ vec_q[0]);
      3'd4:    golden = vec_q[1] ^ vec_q[0];
      3'd5:    golden = ~(vec_q[1] & vec_q[0]);
      default: golden = 1'b0;
    endcase
  end

  assign mismatch = (dut_y != golden);
  assign last_vec = (gate_q == LAST_GATE) && (vec_q == 2'd3);

  always_comb begin
    state_nxt = state_q;
    gate_nxt  = gate_q;
    vec_nxt   = vec_q;
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
    fv_nxt    = fv_q;
    fg_nxt    = fg_q;
    fvec_nxt  = fvec_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A simultaneous abort suppresses the start.
        if (start && !abort) begin
          state_nxt = ST_SETTLE;
          gate_nxt  = 3'd0;
          vec_nxt   = 2'd0;
          cnt_nxt   = SETTLE_LOAD;
          err_nxt   = '0;
          fv_nxt    = 1'b0;
          fg_nxt    = 3'd0;
          fvec_nxt  = 2'd0;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          gate_nxt  = 3'd0;
          vec_nxt   = 2'd0;
        end else if (cnt_q == 4'd0) begin
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if (abort) begin
          // Results gathered so far are kept; this cycle's sample is discarded.
          state_nxt = ST_IDLE;
          gate_nxt  = 3'd0;
          vec_nxt   = 2'd0;
        end else begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_nxt = err_q + 1'b1;
            end
            if (!fv_q) begin
              fv_nxt   = 1'b1;
              fg_nxt   = gate_q;
              fvec_nxt = vec_q;
            end
          end

          if ((STOP_ON_FAIL && mismatch) || last_vec) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = SETTLE_LOAD;
            vec_nxt   = vec_q + 2'd1;
            if (vec_q == 2'd3) begin
              gate_nxt = gate_q + 3'd1;
            end
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gate_q  <= 3'd0;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fg_q    <= 3'd0;
      fvec_q  <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      gate_q  <= gate_nxt;
      vec_q   <= vec_nxt;
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
      fv_q    <= fv_nxt;
      fg_q    <= fg_nxt;
      fvec_q  <= fvec_nxt;
      // Status flags are flopped from next-state so they align with the state they describe.
      busy_q  <= (state_nxt == ST_SETTLE) || (state_nxt == ST_CHECK);
      done_q  <= (state_nxt == ST_DONE);
      pass_q  <= (state_nxt == ST_DONE) && (err_nxt == '0);
    end
  end

  assign gate_sel   = gate_q;
  assign tv_a       = vec_q[1];
  assign tv_b       = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_gate  = fg_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_nor_gate_test_sequencer.sv
module tb_nor_gate_test_sequencer;

  localparam int S     = 2;
  localparam int RUN   = 24 * (S + 1);
  localparam int LIMIT = 300;

`ifdef NOR_SEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort;
  logic       dut_y;
  logic [2:0] gate_sel;
  logic       tv_a, tv_b, busy, done, pass;
  logic [4:0] err_cnt;
  logic       fail_valid;
  logic [2:0] fail_gate;
  logic [1:0] fail_vec;

  // Second instance: narrow counter, gate bank output stuck at 0.
  logic       dut_y2;
  logic [2:0] gate_sel2;
  logic       tv_a2, tv_b2, busy2, done2, pass2;
  logic [2:0] err_cnt2;
  logic       fail_valid2;
  logic [2:0] fail_gate2;
  logic [1:0] fail_vec2;

  int checks = 0;
  int failures = 0;

  // Truth tables indexed by vector {a,b}; rows 6,7 unused.
  logic [3:0]  tt [0:7];
  logic [23:0] fault_mask;
  int          mode;  // 0: ideal bank with fault_mask flips, 1: stuck 0, 2: stuck 1
  logic [4:0]  idx;

  nor_gate_test_sequencer #(.SETTLE_CYCLES(S), .ERR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gate_sel(gate_sel), .tv_a(tv_a), .tv_b(tv_b), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_gate(fail_gate), .fail_vec(fail_vec)
  );

  nor_gate_test_sequencer #(.SETTLE_CYCLES(S), .ERR_W(3)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .gate_sel(gate_sel2), .tv_a(tv_a2), .tv_b(tv_b2), .dut_y(dut_y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
    .fail_valid(fail_valid2), .fail_gate(fail_gate2), .fail_vec(fail_vec2)
  );

  assign dut_y2 = 1'b0;

  always_comb begin
    dut_y = 1'b0;
    idx   = {gate_sel, tv_a, tv_b};
    if (mode == 1) dut_y = 1'b0;
    else if (mode == 2) dut_y = 1'b1;
    else if (gate_sel < 3'd6) dut_y = tt[gate_sel][{tv_a, tv_b}] ^ fault_mask[idx];
  end

  // Which of the 24 sweep points the bank answers wrongly under the current mode.
  function automatic logic [23:0] eff_mask();
    logic [23:0] m;
    logic        g;
    for (int i = 0; i < 24; i++) begin
      g = tt[i / 4][i % 4];
      if (mode == 1) m[i] = g;
      else if (mode == 2) m[i] = ~g;
      else m[i] = fault_mask[i];
    end
    return m;
  endfunction

  // Expected errors (saturated), first failing index, and start-to-done latency.
  task automatic predict(input logic [23:0] m, input int sat,
                         output int errs, output int first, output int lat);
    errs = 0; first = -1; lat = RUN;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) begin
        errs++;
        if (first < 0) first = i;
        if (STOP) begin
          lat = (i + 1) * (S + 1);
          break;
        end
      end
    end
    if (errs > sat) errs = sat;
  endtask

  // Pulse start; count negedges from the start edge until done, and busy samples on the way.
  task automatic start_and_wait(output int cyc, output int bcyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; bcyc = 0;
    while (!done && cyc < LIMIT) begin
      if (busy) bcyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0; fault_mask = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({gate_sel, tv_a, tv_b, busy, done, pass, err_cnt, fail_valid, fail_gate, fail_vec} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {gate_sel, tv_a, tv_b, busy, done, pass, err_cnt, fail_valid, fail_gate, fail_vec});
    end
    // Abort in IDLE must do nothing.
    abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk);
    checks++;
    if ({busy, done, gate_sel} !== 5'd0) begin
      failures++; $display("FAIL idle_abort got=%b exp=0", {busy, done, gate_sel});
    end
  endtask

  task automatic test_ideal();
    int cyc, bcyc;
    mode = 0; fault_mask = '0;
    start_and_wait(cyc, bcyc);
    checks++;
    if (cyc != RUN) begin failures++; $display("FAIL ideal_latency got=%0d exp=%0d", cyc, RUN); end
    checks++;
    if (bcyc != RUN) begin failures++; $display("FAIL ideal_busy_cycles got=%0d exp=%0d", bcyc, RUN); end
    checks++;
    if ({done, pass, busy, err_cnt, fail_valid} !== {3'b110, 5'd0, 1'b0}) begin
      failures++; $display("FAIL ideal_result got=%b exp=110000000", {done, pass, busy, err_cnt, fail_valid});
    end
    repeat (5) @(negedge clk);
    checks++;
    if ({done, gate_sel, tv_a, tv_b} !== {1'b1, 3'd5, 2'b11}) begin
      failures++; $display("FAIL done_hold got=%b exp=110111", {done, gate_sel, tv_a, tv_b});
    end
  endtask

  task automatic test_stuck(input int m);
    int cyc, bcyc, e, f, l, e2, f2, l2;
    mode = m;
    predict(eff_mask(), 31, e, f, l);
    mode = 1;
    predict(eff_mask(), 7, e2, f2, l2);
    mode = m;
    start_and_wait(cyc, bcyc);
    checks++;
    if (cyc != l) begin failures++; $display("FAIL stuck%0d_latency got=%0d exp=%0d", m - 1, cyc, l); end
    checks++;
    if (err_cnt !== 5'(e)) begin failures++; $display("FAIL stuck%0d_err_cnt got=%0d exp=%0d", m - 1, err_cnt, e); end
    checks++;
    if ({fail_valid, fail_gate, fail_vec, pass} !== {1'b1, 3'(f / 4), 2'(f % 4), 1'b0}) begin
      failures++;
      $display("FAIL stuck%0d_first got=v%0d g%0d v%0d p%0d exp=v1 g%0d v%0d p0",
               m - 1, fail_valid, fail_gate, fail_vec, pass, f / 4, f % 4);
    end
    if (m == 1) begin
      checks++;
      if ({done2, err_cnt2} !== {1'b1, 3'(e2)}) begin
        failures++; $display("FAIL narrow_saturate got=d%0d e%0d exp=d1 e%0d", done2, err_cnt2, e2);
      end
    end
    mode = 0;
  endtask

  task automatic test_idle_done_controls();
    logic [4:0] held;
    held = err_cnt;
    abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk);
    checks++;
    if ({done, busy, err_cnt} !== {2'b10, held}) begin
      failures++; $display("FAIL done_abort got=%b exp=%b", {done, busy, err_cnt}, {2'b10, held});
    end
    start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0; @(negedge clk);
    checks++;
    if ({done, busy, err_cnt} !== {2'b10, held}) begin
      failures++; $display("FAIL start_abort_same got=%b exp=%b", {done, busy, err_cnt}, {2'b10, held});
    end
  endtask

  task automatic test_abort();
    int n, cyc, e, f, l;
    mode = 0;
    fault_mask = STOP ? 24'h0 : 24'h000010;
    predict(eff_mask(), 31, e, f, l);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (gate_sel != 3'd3 && n < LIMIT) begin @(negedge clk); n++; end
    checks++;
    if (gate_sel !== 3'd3) begin failures++; $display("FAIL abort_reach_gate3 got=%0d exp=3", gate_sel); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++;
    if ({busy, done, gate_sel, tv_a, tv_b} !== 7'd0) begin
      failures++; $display("FAIL abort_idle got=%b exp=0", {busy, done, gate_sel, tv_a, tv_b});
    end
    checks++;
    if ({err_cnt, fail_valid} !== {5'(e), (e > 0)}) begin
      failures++; $display("FAIL abort_retain got=e%0d v%0d exp=e%0d v%0d", err_cnt, fail_valid, e, e > 0);
    end
    fault_mask = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if ({busy, err_cnt, fail_valid} !== {1'b1, 5'd0, 1'b0}) begin
      failures++; $display("FAIL restart_clear got=%b exp=1000000", {busy, err_cnt, fail_valid});
    end
    cyc = 0;
    while (!done && cyc < LIMIT) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc != RUN || pass !== 1'b1) begin
      failures++; $display("FAIL restart_run got=c%0d p%0d exp=c%0d p1", cyc, pass, RUN);
    end
  endtask

  task automatic test_busy_start_and_reset();
    int n;
    mode = 0; fault_mask = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    // 11 cycles after the start edge the sweep is at point 11/(S+1).
    n = 11 / (S + 1);
    checks++;
    if ({busy, gate_sel, tv_a, tv_b} !== {1'b1, 3'(n / 4), 2'(n % 4)}) begin
      failures++; $display("FAIL start_while_busy got=%b exp=%b", {busy, gate_sel, tv_a, tv_b}, {1'b1, 3'(n / 4), 2'(n % 4)});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    checks++;
    if ({gate_sel, tv_a, tv_b, busy, done, pass, err_cnt, fail_valid, fail_gate, fail_vec} !== 22'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%h exp=0",
               {gate_sel, tv_a, tv_b, busy, done, pass, err_cnt, fail_valid, fail_gate, fail_vec});
    end
  endtask

  task automatic test_random();
    int cyc, bcyc, e, f, l;
    for (int it = 0; it < 8; it++) begin
      mode = 0;
      fault_mask = 24'($urandom & $urandom & $urandom);
      if (it == 0) fault_mask = 24'h800000;  // only the very last point wrong
      predict(eff_mask(), 31, e, f, l);
      start_and_wait(cyc, bcyc);
      checks++;
      if (cyc != l || err_cnt !== 5'(e) || pass !== (e == 0)) begin
        failures++;
        $display("FAIL random%0d_run mask=%h got=c%0d e%0d p%0d exp=c%0d e%0d p%0d",
                 it, fault_mask, cyc, err_cnt, pass, l, e, e == 0);
      end
      if (e > 0) begin
        checks++;
        if ({fail_valid, fail_gate, fail_vec} !== {1'b1, 3'(f / 4), 2'(f % 4)}) begin
          failures++;
          $display("FAIL random%0d_first mask=%h got=g%0d v%0d exp=g%0d v%0d",
                   it, fault_mask, fail_gate, fail_vec, f / 4, f % 4);
        end
      end
    end
  endtask

  initial begin
    tt[0] = 4'b0011;  // NOT a
    tt[1] = 4'b1000;  // AND
    tt[2] = 4'b1110;  // OR
    tt[3] = 4'b1001;  // XNOR
    tt[4] = 4'b0110;  // XOR
    tt[5] = 4'b0111;  // NAND
    tt[6] = 4'b0000;
    tt[7] = 4'b0000;
    test_reset();
    test_ideal();
    test_stuck(1);
    test_stuck(2);
    test_idle_done_controls();
    test_abort();
    test_busy_start_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
